rom_stream_loader: RTL and testbench
====================================

ROM_STREAM_LOADER -- requirements
Module: rom_stream_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning ROM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, meaning ROM address width (64 words).
REQ-003 SHALL have port sysclk  input  1  single clock; every flop is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle load request.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first ROM address, sampled on start.
REQ-007 SHALL have port word_count  input  ADDR_WIDTH+1  number of words to load (1..64), sampled on start.
REQ-008 SHALL have port in_valid / in_ready / in_data  input/output/input  1/1/DATA_WIDTH  word stream handshake.
REQ-009 SHALL have port rom_we, rom_select, rom_addr, rom_wd  output  1/1/ADDR_WIDTH/DATA_WIDTH  ROM host-write port.
REQ-010 SHALL have port rom_rd  input  DATA_WIDTH  ROM read data, combinational from rom_addr.
REQ-011 SHALL have port busy, done, error  output  1 each  status; done and error are one-cycle pulses.
REQ-012 SHALL have port words_written  output  ADDR_WIDTH+1  count of ROM writes in the current or last load.

Function
REQ-013 SHALL implement states IDLE, LOAD, DRAIN, VERIFY, and FINISH.
REQ-014 SHALL, in IDLE, go to LOAD on start with word_count in 1..64, latch base_addr and word_count, and clear words_written and the checksum.
REQ-015 SHALL, on start with word_count==0 or word_count>64, pulse error the next cycle, stay in IDLE, and perform no writes.
REQ-016 SHALL drive in_ready=1 only in LOAD, and a transfer occurs when in_valid & in_ready.
REQ-017 SHALL, on a transfer, register rom_we=1, rom_addr=base_addr+index (mod 2^ADDR_WIDTH, wraps 63->0), and rom_wd=in_data; the write appears exactly one cycle after its handshake.
REQ-018 SHALL hold rom_we=0 in any cycle not directly following a transfer; in_valid low stalls LOAD without timeout.
REQ-019 SHALL increment words_written on every asserted rom_we and add the written word to a DATA_WIDTH modulo-2^DATA_WIDTH checksum.
REQ-020 SHALL go from LOAD to DRAIN on the handshake of the last word, and DRAIN lasts one cycle, during which the final write is issued.
REQ-021 SHALL assert rom_select=1 whenever busy=1, and rom_select=0 otherwise.
REQ-022 SHALL hold busy=1 in LOAD, DRAIN, and VERIFY, and busy=0 in IDLE and FINISH.
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL go from FINISH to IDLE after one cycle, pulsing done there unless a verify mismatch pulses error instead.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force IDLE, with rom_we=0, rom_select=0, rom_addr=0, rom_wd=0, in_ready=0, busy=0, done=0, error=0, words_written=0, and checksum=0.
REQ-026 SHALL, on rst_n asserted mid-load, abandon the load, and no further ROM writes occur; partial ROM content remains.

Configuration
REQ-027 SHALL, with ROM_LOADER_VERIFY_EN defined, go from DRAIN to VERIFY, step rom_addr from base_addr for word_count cycles with rom_we=0, sum rom_rd into a second checksum sampled each cycle, then enter FINISH; a mismatch with the write checksum gives error, otherwise done.
REQ-028 SHALL, without ROM_LOADER_VERIFY_EN, have DRAIN go directly to FINISH, have the VERIFY state and the read-back checksum logic absent, leave rom_rd unused, and have done always pulse.

Structure
REQ-029 SHALL place the state encoding enum and the ROM depth constant (64) in the shared package soc_pkg.
REQ-030 SHALL be a single module with no sub-modules; the checksum accumulator is inline.

Verification
REQ-031 SHALL cover: start base=0, count=4, continuous in_valid, data 0x11,0x22,0x33,0x44 -> writes at addr 0..3 on consecutive cycles one cycle after each handshake; done pulses; words_written=4.
REQ-032 SHALL cover: base=62, count=4 -> writes at addresses 62,63,0,1.
REQ-033 SHALL cover: in_valid toggled every other cycle, count=3 -> exactly 3 writes; rom_we never asserted without a preceding handshake.
REQ-034 SHALL cover: start with count=0 and with count=65 -> error pulse, no rom_we, busy stays 0.
REQ-035 SHALL cover: verify enabled, bench ROM model corrupts address 2 -> error pulse, no done; with a clean model -> done pulse after count verify cycles.
REQ-036 SHALL cover: rst_n low after 2 of 5 writes -> outputs immediately at reset values; after release a new start loads normally.

Source files
------------

// File: rtl/soc_pkg.sv
// ============================================================================
// Package  : soc_pkg
// Brief    : Shared ROM depth constant and loader state encoding.
//            The VERIFY state exists only when ROM_LOADER_VERIFY_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

package soc_pkg;

  localparam int c_rom_depth = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
`ifdef ROM_LOADER_VERIFY_EN
    ST_VERIFY = 3'd3,
`endif
    ST_FINISH = 3'd4
  } loader_state_e;

endpackage : soc_pkg

`default_nettype wire

// File: rtl/rom_stream_loader.sv
// ============================================================================
// Module   : rom_stream_loader
// Brief    : Loads a stream of words into a ROM host-write port, one registered
//            write per handshake. ROM_LOADER_VERIFY_EN adds a read-back checksum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rom_stream_loader
  import soc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  rom_we,
  output logic                  rom_select,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [DATA_WIDTH-1:0] rom_wd,
  input  logic [DATA_WIDTH-1:0] rom_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam logic [ADDR_WIDTH:0] c_max_count = (ADDR_WIDTH+1)'(c_rom_depth);

  loader_state_e          r_state;
  loader_state_e          w_next_state;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [ADDR_WIDTH:0]    r_count;
  logic [ADDR_WIDTH:0]    r_index;
  logic [DATA_WIDTH-1:0]  r_checksum;
  logic                   w_count_ok;
  logic                   w_xfer;
  logic                   w_last_index;

`ifdef ROM_LOADER_VERIFY_EN
  logic [DATA_WIDTH-1:0]  r_verify_sum;
`else
  logic                   w_unused_rd;
  assign w_unused_rd = ^rom_rd;
`endif

  assign w_count_ok   = (word_count != '0) && (word_count <= c_max_count);
  assign w_xfer       = in_valid && (r_state == ST_LOAD);
  assign w_last_index = (r_index == r_count - 1'b1);
  assign rom_select   = busy;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && w_count_ok) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_xfer && w_last_index) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
`ifdef ROM_LOADER_VERIFY_EN
        w_next_state = ST_VERIFY;
`else
        w_next_state = ST_FINISH;
`endif
      end
`ifdef ROM_LOADER_VERIFY_EN
      ST_VERIFY: begin
        busy = 1'b1;
        if (w_last_index) w_next_state = ST_FINISH;
      end
`endif
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_base        <= '0;
      r_count       <= '0;
      r_index       <= '0;
      r_checksum    <= '0;
      rom_we        <= 1'b0;
      rom_addr      <= '0;
      rom_wd        <= '0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
`ifdef ROM_LOADER_VERIFY_EN
      r_verify_sum  <= '0;
`endif
    end else begin
      rom_we <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;

      // Accounting follows the write actually presented to the ROM.
      if (rom_we) begin
        words_written <= words_written + 1'b1;
        r_checksum    <= r_checksum + rom_wd;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_count_ok) begin
              r_base        <= base_addr;
              r_count       <= word_count;
              r_index       <= '0;
              words_written <= '0;
              r_checksum    <= '0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            rom_we   <= 1'b1;
            rom_addr <= r_base + r_index[ADDR_WIDTH-1:0];
            rom_wd   <= in_data;
            r_index  <= r_index + 1'b1;
          end
        end
`ifdef ROM_LOADER_VERIFY_EN
        ST_DRAIN: begin
          rom_addr     <= r_base;
          r_index      <= '0;
          r_verify_sum <= '0;
        end
        ST_VERIFY: begin
          r_verify_sum <= r_verify_sum + rom_rd;
          rom_addr     <= rom_addr + 1'b1;
          r_index      <= r_index + 1'b1;
        end
        ST_FINISH: begin
          if (r_verify_sum != r_checksum) error <= 1'b1;
          else                            done  <= 1'b1;
        end
`else
        ST_FINISH: done <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule : rom_stream_loader

`default_nettype wire

// File: tb/tb_rom_stream_loader.sv
// ============================================================================
// Module   : tb_rom_stream_loader
// Brief    : Scoreboard bench for rom_stream_loader with a behavioural ROM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rom_stream_loader;

`ifdef ROM_LOADER_VERIFY_EN
  localparam bit c_verify_on = 1'b1;
`else
  localparam bit c_verify_on = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  word_count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        rom_we;
  logic        rom_select;
  logic [5:0]  rom_addr;
  logic [31:0] rom_wd;
  logic [31:0] rom_rd;
  logic        busy;
  logic        done;
  logic        error;
  logic [6:0]  words_written;

  rom_stream_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .rom_we(rom_we), .rom_select(rom_select),
    .rom_addr(rom_addr), .rom_wd(rom_wd), .rom_rd(rom_rd), .busy(busy),
    .done(done), .error(error), .words_written(words_written)
  );

  always #5 sysclk = ~sysclk;

  // Behavioural ROM; corrupt flips bit 0 of address 2 on the read side.
  logic [31:0] mem [64];
  bit          corrupt = 1'b0;
  always @(posedge sysclk) if (rom_we && rom_select) mem[rom_addr] <= rom_wd;
  assign rom_rd = mem[rom_addr] ^ ((corrupt && rom_addr == 6'd2) ? 32'h1 : 32'h0);

  typedef struct { logic [5:0] addr; logic [31:0] data; } wr_t;
  typedef struct { bit is_err; int words; int lat; } evt_t;

  wr_t  exp_wr  [$];
  evt_t exp_evt [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] tbl [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every ROM write and status pulse with the scoreboard.
  initial begin
    bit prev_hs;
    int cyc;
    int last_hs_cyc;
    prev_hs = 1'b0;
    cyc = 0;
    last_hs_cyc = 0;
    forever begin
      @(negedge sysclk);
      if (!rst_n) begin
        prev_hs = 1'b0;
      end else begin
        check("we_follows_handshake", 64'(rom_we), 64'(prev_hs));
        check("select_eq_busy", 64'(rom_select), 64'(busy));
        if (rom_we) begin
          if (exp_wr.size() == 0) begin
            check("unexpected_write", 64'(rom_addr), 64'hFFFF);
          end else begin
            wr_t w;
            w = exp_wr.pop_front();
            check("write_addr", 64'(rom_addr), 64'(w.addr));
            check("write_data", 64'(rom_wd), 64'(w.data));
          end
        end
        if (done || error) begin
          check("done_error_exclusive", 64'(done && error), 64'h0);
          if (exp_evt.size() == 0) begin
            check("unexpected_status", {62'h0, done, error}, 64'h0);
          end else begin
            evt_t e;
            e = exp_evt.pop_front();
            check("status_is_error", 64'(error), 64'(e.is_err));
            if (e.words >= 0) check("words_written", 64'(words_written), 64'(e.words));
            if (e.lat >= 0) check("status_latency", 64'(cyc - last_hs_cyc), 64'(e.lat));
          end
        end
        if (in_valid && in_ready) last_hs_cyc = cyc;
        prev_hs = in_valid && in_ready;
      end
      cyc++;
    end
  end

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while ((exp_wr.size() != 0 || exp_evt.size() != 0) && c < budget) begin
      @(posedge sysclk); #1;
      c++;
    end
    check("scoreboard_drained", 64'(exp_wr.size() + exp_evt.size()), 64'h0);
    exp_wr.delete();
    exp_evt.delete();
    repeat (2) begin @(posedge sysclk); #1; end
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
  task automatic run_load(input int base, input int count, input int mode, input bit use_tbl);
    logic [31:0] d [$];
    bit hits2;
    int i;
    int k;
    hits2 = 1'b0;
    for (int n = 0; n < count; n++) begin
      d.push_back(use_tbl ? tbl[n] : $urandom);
      exp_wr.push_back('{addr: 6'((base + n) % 64), data: d[n]});
      if (((base + n) % 64) == 2) hits2 = 1'b1;
    end
    exp_evt.push_back('{is_err: c_verify_on && corrupt && hits2, words: count,
                        lat: 3 + (c_verify_on ? count : 0)});
    start = 1'b1; base_addr = 6'(base); word_count = 7'(count);
    @(posedge sysclk); #1;
    start = 1'b0;
    i = 0;
    k = 0;
    while (i < count && k < 4000) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = k[0];
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = d[i];
      @(negedge sysclk);
      if (in_valid && in_ready) i++;
      @(posedge sysclk); #1;
      k++;
    end
    in_valid = 1'b0;
    check("load_words_accepted", 64'(i), 64'(count));
    wait_drain(count + 50);
  endtask

  task automatic bad_start(input int count);
    exp_evt.push_back('{is_err: 1'b1, words: -1, lat: -1});
    start = 1'b1; base_addr = 6'd5; word_count = 7'(count);
    @(posedge sysclk); #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge sysclk);
      check("bad_count_busy", 64'(busy), 64'h0);
      @(posedge sysclk); #1;
    end
    wait_drain(10);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_outputs"},
          {rom_we, rom_select, in_ready, busy, done, error, 58'h0}, 64'h0);
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'h0);
    check({tag, "_rom_wd"}, 64'(rom_wd), 64'h0);
    check({tag, "_words_written"}, 64'(words_written), 64'h0);
  endtask

  initial begin
    for (int n = 0; n < 64; n++) mem[n] = 32'h0;
    tbl[0] = 32'h11; tbl[1] = 32'h22; tbl[2] = 32'h33; tbl[3] = 32'h44;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge sysclk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge sysclk); #1;

    run_load(0, 4, 0, 1'b1);
    run_load(62, 4, 0, 1'b0);
    run_load(10, 3, 1, 1'b0);
    bad_start(0);
    bad_start(65);

    corrupt = 1'b1;
    run_load(0, 4, 0, 1'b0);
    corrupt = 1'b0;
    run_load(0, 4, 0, 1'b0);

    // Mid-load reset after the second of five writes.
    begin
      logic [31:0] d0, d1;
      d0 = $urandom; d1 = $urandom;
      exp_wr.push_back('{addr: 6'd20, data: d0});
      exp_wr.push_back('{addr: 6'd21, data: d1});
      start = 1'b1; base_addr = 6'd20; word_count = 7'd5;
      @(posedge sysclk); #1;
      start = 1'b0;
      in_valid = 1'b1; in_data = d0;
      @(posedge sysclk); #1;
      in_data = d1;
      @(posedge sysclk); #1;
      in_valid = 1'b0;
      @(posedge sysclk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_values("midload_reset");
      check("partial_rom_word1", 64'(mem[21]), 64'(d1));
      repeat (2) @(posedge sysclk);
      #1;
      rst_n = 1'b1;
      wait_drain(5);
    end
    run_load(30, 5, 0, 1'b0);

    for (int r = 0; r < 8; r++)
      run_load($urandom_range(0, 63), $urandom_range(1, 64), 2, 1'b0);
    run_load(63, 64, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_rom_stream_loader

`default_nettype wire
